// File: rtl/race_progress_tracker.sv
// Race progress tracker: per-frame distance integration and race state machine.
// Optional elapsed-race frame timer enabled by defining RACE_PROGRESS_TIMER_EN.
module race_progress_tracker #(
  parameter int          TRACK_LENGTH     = 20000,
  parameter int          FINISH_OFFSET    = 600,
  parameter int          COUNTDOWN_FRAMES = 180,
  parameter int          SPEED_SHIFT      = 2,
  parameter logic [10:0] MAX_SPEED        = 11'd400
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        frame_start,
  input  logic        start_race,
  input  logic [0:10] speed,
  input  logic        crash,
  output int          distance_drove,
  output int          track_length,
  output logic [1:0]  race_state,
  output logic [1:0]  countdown_sec,
  output logic        finished_pulse,
  output logic [0:15] race_time_frames
);

  localparam int CNT_W     = $clog2(COUNTDOWN_FRAMES + 1);
  localparam int FINISH_AT = TRACK_LENGTH + FINISH_OFFSET;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACING    = 2'd2,
    FINISHED  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  int               dist_reg, dist_next;
  int               track_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;
  logic [10:0]      speed_sat;
  int               step;
  int               sum;
  int               sec_full;

  // Saturated speed scaled down to a per-frame distance step.
  always_comb begin
    speed_sat = (speed > MAX_SPEED) ? MAX_SPEED : speed;
    step      = int'({21'd0, speed_sat >> SPEED_SHIFT});
    sum       = dist_reg + step;
  end

  always_comb begin
    state_next = state_reg;
    dist_next  = dist_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    if (frame_start) begin
      case (state_reg)
        IDLE: begin
          dist_next = 0;
          if (start_race) begin
            state_next = COUNTDOWN;
            cnt_next   = CNT_W'(COUNTDOWN_FRAMES - 1);
          end
        end
        COUNTDOWN: begin
          if (cnt_reg == '0) state_next = RACING;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        RACING: begin
          // A crash frame never advances, so it can never finish the race.
          if (!crash) begin
            if (sum >= FINISH_AT) begin
              dist_next  = FINISH_AT;
              state_next = FINISHED;
              pulse_next = 1'b1;
            end else begin
              dist_next = sum;
            end
          end
        end
        FINISHED: begin
          if (start_race) begin
            state_next = IDLE;
            dist_next  = 0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      dist_reg  <= 0;
      track_reg <= TRACK_LENGTH;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dist_reg  <= dist_next;
      track_reg <= TRACK_LENGTH;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    sec_full      = int'(cnt_reg) / 60 + 1;
    countdown_sec = 2'd0;
    if (state_reg == COUNTDOWN)
      countdown_sec = (sec_full > 3) ? 2'd3 : 2'(sec_full);
  end

`ifdef RACE_PROGRESS_TIMER_EN
  logic [15:0] time_reg, time_next;

  always_comb begin
    time_next = time_reg;
    if (frame_start) begin
      if (state_reg == IDLE && start_race)
        time_next = '0;
      else if (state_reg == RACING && time_reg != 16'hFFFF)
        time_next = time_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) time_reg <= '0;
    else         time_reg <= time_next;
  end

  assign race_time_frames = time_reg;
`else
  assign race_time_frames = '0;
`endif

  assign distance_drove = dist_reg;
  assign track_length   = track_reg;
  assign race_state     = state_reg;
  assign finished_pulse = pulse_reg;

endmodule
